calc_port_responder: RTL

//  Responder end of the calculator request port: accepts a command plus two

---
 rtl/calc_port_responder_pkg.sv | 27 ++
 rtl/calc_port_responder_if.sv | 14 +
 rtl/calc_port_responder_alu_core.sv | 38 +++
 rtl/calc_port_responder.sv | 107 ++++++++++
 4 files changed

// File: rtl/calc_port_responder_pkg.sv
// Shared types and constants for the calculator request port and its responder.
package calc_pkg;

  localparam int DW = 32;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_EXEC,
    S_RESP
  } state_e;

endpackage

// File: rtl/calc_port_responder_if.sv
// Requester <-> responder port: command, serial operands, response and busy.
interface calc_port_responder_if;
  import calc_pkg::*;

  logic [3:0]    cmd_in;
  logic [DW-1:0] data_in;
  logic [1:0]    out_resp;
  logic [DW-1:0] out_data;
  logic          busy;

  modport master (output cmd_in, data_in, input  out_resp, out_data, busy);
  modport slave  (input  cmd_in, data_in, output out_resp, out_data, busy);

endinterface

// File: rtl/calc_port_responder_alu_core.sv
// Combinational calculator core: unsigned ADD/SUB with range errors, logical shifts.
module calc_alu_core
  import calc_pkg::*;
#(
  parameter int DW = calc_pkg::DW
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  output logic [DW-1:0] result,
  output logic          err
);

  logic [DW:0] sum;

  assign sum = {1'b0, op1} + {1'b0, op2};

  // Any error forces the result to zero so the response data is clean.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    result = '0;
    err    = 1'b0;
    case (cmd)
      CMD_ADD: begin
        if (sum[DW]) err = 1'b1;
        else         result = sum[DW-1:0];
      end
      CMD_SUB: begin
        if (op2 > op1) err = 1'b1;
        else           result = op1 - op2;
      end
      CMD_SHL: result = op1 << op2[4:0];
      CMD_SHR: result = op1 >> op2[4:0];
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// Per-port responder: captures cmd/op1 then op2, waits EXEC_LAT cycles, returns a one-cycle response.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int EXEC_LAT = 2,
  parameter int DW       = calc_pkg::DW
) (
  input  logic                  c_clk,
  input  logic                  reset,
  calc_port_responder_if.slave  port
);

  localparam int CW = $clog2(EXEC_LAT + 1);

  state_e        state_q, state_d;
  logic [3:0]    cmd_q;
  logic [DW-1:0] op1_q, op2_q;
  logic [CW-1:0] cnt_q;
  resp_e         resp_q;
  logic [DW-1:0] data_q;

  logic          load_op1, load_op2, exec_done;
  logic [DW-1:0] alu_result;
  logic          alu_err;

  // EXEC counts EXEC_LAT edges; the edge after that registers the core output,
  // which places the response at cmd edge + 2 + EXEC_LAT.
  assign exec_done = (cnt_q == CW'(EXEC_LAT));

  calc_alu_core #(.DW(DW)) u_core (
    .cmd    (cmd_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    state_d  = state_q;
    load_op1 = 1'b0;
    load_op2 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (port.cmd_in != CMD_NONE) begin
          load_op1 = 1'b1;
          state_d  = S_OP2;
        end
      end
      S_OP2: begin
        load_op2 = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) state_d = S_RESP;
      end
      S_RESP: begin
        // A new command here starts the next request without an idle bubble.
        if (port.cmd_in != CMD_NONE) begin
          load_op1 = 1'b1;
          state_d  = S_OP2;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_NONE;
      data_q <= '0;
    end else begin
      if (load_op1) begin
        cmd_q <= port.cmd_in;
        op1_q <= port.data_in;
      end
      if (load_op2) op2_q <= port.data_in;

      if (state_q == S_EXEC && !exec_done) cnt_q <= cnt_q + CW'(1);
      else                                 cnt_q <= '0;

      if (state_q == S_EXEC && exec_done) begin
        resp_q <= alu_err ? RESP_ERR : RESP_OK;
        data_q <= alu_result;
      end else begin
        resp_q <= RESP_NONE;
        data_q <= '0;
      end
    end
  end

  assign port.out_resp = resp_q;
  assign port.out_data = data_q;
  assign port.busy     = (state_q != S_IDLE);

endmodule
